// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, FSM encoding and GF(2^8) helpers
// Purpose: common definitions for the iterative AES cipher and its S-box.
// Contents: Nb, FSM state enum, xtime/gmul3, ShiftRows source-index mapping.
package aes_pkg;

  localparam int Nb = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

  // Multiply by x (0x02) in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] a);
    return xtime(a) ^ a;
  endfunction

  // Output byte k sits at (row k%4, column k/4); it comes from the same
  // row, column (c+r) mod 4 of the input.
  function automatic int shift_rows_src(input int k);
    int r;
    int c;
    r = k % Nb;
    c = k / Nb;
    return Nb * ((c + r) % Nb) + r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational forward AES S-box
// Purpose: 8-bit SubBytes lookup, shared by the cipher and key expansion.
// Ports: in_byte (8) -> out_byte (8).
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  always_comb begin
    out_byte = 8'h00;
    case (in_byte)
      8'h00: out_byte = 8'h63; 8'h01: out_byte = 8'h7c; 8'h02: out_byte = 8'h77; 8'h03: out_byte = 8'h7b; 8'h04: out_byte = 8'hf2; 8'h05: out_byte = 8'h6b; 8'h06: out_byte = 8'h6f; 8'h07: out_byte = 8'hc5;
      8'h08: out_byte = 8'h30; 8'h09: out_byte = 8'h01; 8'h0a: out_byte = 8'h67; 8'h0b: out_byte = 8'h2b; 8'h0c: out_byte = 8'hfe; 8'h0d: out_byte = 8'hd7; 8'h0e: out_byte = 8'hab; 8'h0f: out_byte = 8'h76;
      8'h10: out_byte = 8'hca; 8'h11: out_byte = 8'h82; 8'h12: out_byte = 8'hc9; 8'h13: out_byte = 8'h7d; 8'h14: out_byte = 8'hfa; 8'h15: out_byte = 8'h59; 8'h16: out_byte = 8'h47; 8'h17: out_byte = 8'hf0;
      8'h18: out_byte = 8'had; 8'h19: out_byte = 8'hd4; 8'h1a: out_byte = 8'ha2; 8'h1b: out_byte = 8'haf; 8'h1c: out_byte = 8'h9c; 8'h1d: out_byte = 8'ha4; 8'h1e: out_byte = 8'h72; 8'h1f: out_byte = 8'hc0;
      8'h20: out_byte = 8'hb7; 8'h21: out_byte = 8'hfd; 8'h22: out_byte = 8'h93; 8'h23: out_byte = 8'h26; 8'h24: out_byte = 8'h36; 8'h25: out_byte = 8'h3f; 8'h26: out_byte = 8'hf7; 8'h27: out_byte = 8'hcc;
      8'h28: out_byte = 8'h34; 8'h29: out_byte = 8'ha5; 8'h2a: out_byte = 8'he5; 8'h2b: out_byte = 8'hf1; 8'h2c: out_byte = 8'h71; 8'h2d: out_byte = 8'hd8; 8'h2e: out_byte = 8'h31; 8'h2f: out_byte = 8'h15;
      8'h30: out_byte = 8'h04; 8'h31: out_byte = 8'hc7; 8'h32: out_byte = 8'h23; 8'h33: out_byte = 8'hc3; 8'h34: out_byte = 8'h18; 8'h35: out_byte = 8'h96; 8'h36: out_byte = 8'h05; 8'h37: out_byte = 8'h9a;
      8'h38: out_byte = 8'h07; 8'h39: out_byte = 8'h12; 8'h3a: out_byte = 8'h80; 8'h3b: out_byte = 8'he2; 8'h3c: out_byte = 8'heb; 8'h3d: out_byte = 8'h27; 8'h3e: out_byte = 8'hb2; 8'h3f: out_byte = 8'h75;
      8'h40: out_byte = 8'h09; 8'h41: out_byte = 8'h83; 8'h42: out_byte = 8'h2c; 8'h43: out_byte = 8'h1a; 8'h44: out_byte = 8'h1b; 8'h45: out_byte = 8'h6e; 8'h46: out_byte = 8'h5a; 8'h47: out_byte = 8'ha0;
      8'h48: out_byte = 8'h52; 8'h49: out_byte = 8'h3b; 8'h4a: out_byte = 8'hd6; 8'h4b: out_byte = 8'hb3; 8'h4c: out_byte = 8'h29; 8'h4d: out_byte = 8'he3; 8'h4e: out_byte = 8'h2f; 8'h4f: out_byte = 8'h84;
      8'h50: out_byte = 8'h53; 8'h51: out_byte = 8'hd1; 8'h52: out_byte = 8'h00; 8'h53: out_byte = 8'hed; 8'h54: out_byte = 8'h20; 8'h55: out_byte = 8'hfc; 8'h56: out_byte = 8'hb1; 8'h57: out_byte = 8'h5b;
      8'h58: out_byte = 8'h6a; 8'h59: out_byte = 8'hcb; 8'h5a: out_byte = 8'hbe; 8'h5b: out_byte = 8'h39; 8'h5c: out_byte = 8'h4a; 8'h5d: out_byte = 8'h4c; 8'h5e: out_byte = 8'h58; 8'h5f: out_byte = 8'hcf;
      8'h60: out_byte = 8'hd0; 8'h61: out_byte = 8'hef; 8'h62: out_byte = 8'haa; 8'h63: out_byte = 8'hfb; 8'h64: out_byte = 8'h43; 8'h65: out_byte = 8'h4d; 8'h66: out_byte = 8'h33; 8'h67: out_byte = 8'h85;
      8'h68: out_byte = 8'h45; 8'h69: out_byte = 8'hf9; 8'h6a: out_byte = 8'h02; 8'h6b: out_byte = 8'h7f; 8'h6c: out_byte = 8'h50; 8'h6d: out_byte = 8'h3c; 8'h6e: out_byte = 8'h9f; 8'h6f: out_byte = 8'ha8;
      8'h70: out_byte = 8'h51; 8'h71: out_byte = 8'ha3; 8'h72: out_byte = 8'h40; 8'h73: out_byte = 8'h8f; 8'h74: out_byte = 8'h92; 8'h75: out_byte = 8'h9d; 8'h76: out_byte = 8'h38; 8'h77: out_byte = 8'hf5;
      8'h78: out_byte = 8'hbc; 8'h79: out_byte = 8'hb6; 8'h7a: out_byte = 8'hda; 8'h7b: out_byte = 8'h21; 8'h7c: out_byte = 8'h10; 8'h7d: out_byte = 8'hff; 8'h7e: out_byte = 8'hf3; 8'h7f: out_byte = 8'hd2;
      8'h80: out_byte = 8'hcd; 8'h81: out_byte = 8'h0c; 8'h82: out_byte = 8'h13; 8'h83: out_byte = 8'hec; 8'h84: out_byte = 8'h5f; 8'h85: out_byte = 8'h97; 8'h86: out_byte = 8'h44; 8'h87: out_byte = 8'h17;
      8'h88: out_byte = 8'hc4; 8'h89: out_byte = 8'ha7; 8'h8a: out_byte = 8'h7e; 8'h8b: out_byte = 8'h3d; 8'h8c: out_byte = 8'h64; 8'h8d: out_byte = 8'h5d; 8'h8e: out_byte = 8'h19; 8'h8f: out_byte = 8'h73;
      8'h90: out_byte = 8'h60; 8'h91: out_byte = 8'h81; 8'h92: out_byte = 8'h4f; 8'h93: out_byte = 8'hdc; 8'h94: out_byte = 8'h22; 8'h95: out_byte = 8'h2a; 8'h96: out_byte = 8'h90; 8'h97: out_byte = 8'h88;
      8'h98: out_byte = 8'h46; 8'h99: out_byte = 8'hee; 8'h9a: out_byte = 8'hb8; 8'h9b: out_byte = 8'h14; 8'h9c: out_byte = 8'hde; 8'h9d: out_byte = 8'h5e; 8'h9e: out_byte = 8'h0b; 8'h9f: out_byte = 8'hdb;
      8'ha0: out_byte = 8'he0; 8'ha1: out_byte = 8'h32; 8'ha2: out_byte = 8'h3a; 8'ha3: out_byte = 8'h0a; 8'ha4: out_byte = 8'h49; 8'ha5: out_byte = 8'h06; 8'ha6: out_byte = 8'h24; 8'ha7: out_byte = 8'h5c;
      8'ha8: out_byte = 8'hc2; 8'ha9: out_byte = 8'hd3; 8'haa: out_byte = 8'hac; 8'hab: out_byte = 8'h62; 8'hac: out_byte = 8'h91; 8'had: out_byte = 8'h95; 8'hae: out_byte = 8'he4; 8'haf: out_byte = 8'h79;
      8'hb0: out_byte = 8'he7; 8'hb1: out_byte = 8'hc8; 8'hb2: out_byte = 8'h37; 8'hb3: out_byte = 8'h6d; 8'hb4: out_byte = 8'h8d; 8'hb5: out_byte = 8'hd5; 8'hb6: out_byte = 8'h4e; 8'hb7: out_byte = 8'ha9;
      8'hb8: out_byte = 8'h6c; 8'hb9: out_byte = 8'h56; 8'hba: out_byte = 8'hf4; 8'hbb: out_byte = 8'hea; 8'hbc: out_byte = 8'h65; 8'hbd: out_byte = 8'h7a; 8'hbe: out_byte = 8'hae; 8'hbf: out_byte = 8'h08;
      8'hc0: out_byte = 8'hba; 8'hc1: out_byte = 8'h78; 8'hc2: out_byte = 8'h25; 8'hc3: out_byte = 8'h2e; 8'hc4: out_byte = 8'h1c; 8'hc5: out_byte = 8'ha6; 8'hc6: out_byte = 8'hb4; 8'hc7: out_byte = 8'hc6;
      8'hc8: out_byte = 8'he8; 8'hc9: out_byte = 8'hdd; 8'hca: out_byte = 8'h74; 8'hcb: out_byte = 8'h1f; 8'hcc: out_byte = 8'h4b; 8'hcd: out_byte = 8'hbd; 8'hce: out_byte = 8'h8b; 8'hcf: out_byte = 8'h8a;
      8'hd0: out_byte = 8'h70; 8'hd1: out_byte = 8'h3e; 8'hd2: out_byte = 8'hb5; 8'hd3: out_byte = 8'h66; 8'hd4: out_byte = 8'h48; 8'hd5: out_byte = 8'h03; 8'hd6: out_byte = 8'hf6; 8'hd7: out_byte = 8'h0e;
      8'hd8: out_byte = 8'h61; 8'hd9: out_byte = 8'h35; 8'hda: out_byte = 8'h57; 8'hdb: out_byte = 8'hb9; 8'hdc: out_byte = 8'h86; 8'hdd: out_byte = 8'hc1; 8'hde: out_byte = 8'h1d; 8'hdf: out_byte = 8'h9e;
      8'he0: out_byte = 8'he1; 8'he1: out_byte = 8'hf8; 8'he2: out_byte = 8'h98; 8'he3: out_byte = 8'h11; 8'he4: out_byte = 8'h69; 8'he5: out_byte = 8'hd9; 8'he6: out_byte = 8'h8e; 8'he7: out_byte = 8'h94;
      8'he8: out_byte = 8'h9b; 8'he9: out_byte = 8'h1e; 8'hea: out_byte = 8'h87; 8'heb: out_byte = 8'he9; 8'hec: out_byte = 8'hce; 8'hed: out_byte = 8'h55; 8'hee: out_byte = 8'h28; 8'hef: out_byte = 8'hdf;
      8'hf0: out_byte = 8'h8c; 8'hf1: out_byte = 8'ha1; 8'hf2: out_byte = 8'h89; 8'hf3: out_byte = 8'h0d; 8'hf4: out_byte = 8'hbf; 8'hf5: out_byte = 8'he6; 8'hf6: out_byte = 8'h42; 8'hf7: out_byte = 8'h68;
      8'hf8: out_byte = 8'h41; 8'hf9: out_byte = 8'h99; 8'hfa: out_byte = 8'h2d; 8'hfb: out_byte = 8'h0f; 8'hfc: out_byte = 8'hb0; 8'hfd: out_byte = 8'h54; 8'hfe: out_byte = 8'hbb; 8'hff: out_byte = 8'h16;
      default: out_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/aes_cipher_iter.sv
// rtl/aes_cipher_iter.sv - iterative AES encryption core, one round per clock
// Purpose: encrypts one 128-bit block per in handshake using an externally
//   expanded key schedule; AES-128/192/256 selected by Nk/Nr.
// Ports: clk, rst_n (async, active-low);
//   in_valid/in_ready/in_block[0:127]   plaintext handshake;
//   round_keys[0:128*(Nr+1)-1]          flat key schedule, round r at [128*r +:128];
//   out_valid/out_ready/out_block[0:127] ciphertext handshake;
//   busy                                 high while a block is in flight or held.
import aes_pkg::*;

module aes_cipher_iter #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [0:127]             in_block,
  input  logic [0:128*(Nr+1)-1]    round_keys,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [0:127]             out_block,
  output logic                     busy
);

  if (Nr != Nk + 6) begin : g_bad_nr
    $error("aes_cipher_iter: Nr must equal Nk+6");
  end
  if (Nk != 4 && Nk != 6 && Nk != 8) begin : g_bad_nk
    $error("aes_cipher_iter: Nk must be 4, 6 or 8");
  end

  localparam logic [3:0] NR_LAST = 4'(Nr);

  aes_state_e   fsm_q, fsm_d;
  logic [3:0]   round_ctr_q, round_ctr_d;
  logic [0:127] state_q, state_d;
  logic [0:127] out_block_q, out_block_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;

  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [0:127] round_key;
  logic [0:127] round_out;
  logic         last_round;

  // One MixColumns column: rows are {2,3,1,1} rotated right per output byte.
  function automatic logic [31:0] mix_column(input logic [7:0] a0, input logic [7:0] a1,
                                             input logic [7:0] a2, input logic [7:0] a3);
    logic [7:0] b0, b1, b2, b3;
    b0 = xtime(a0) ^ gmul3(a1) ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ gmul3(a2) ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ gmul3(a3);
    b3 = gmul3(a0) ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  for (genvar k = 0; k < 16; k++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (state_q[8*k +: 8]),
      .out_byte (sb[k])
    );
  end

  // round_ctr only reaches Nr while in ROUND, so the slice stays in range.
  assign round_key  = round_keys[128*int'(round_ctr_q) +: 128];
  assign last_round = (round_ctr_q == NR_LAST);

  always_comb begin
    for (int k = 0; k < 16; k++) begin
      sr[k] = sb[shift_rows_src(k)];
    end
    round_out = '0;
    for (int c = 0; c < Nb; c++) begin
      if (last_round) begin
        round_out[32*c +: 32] = {sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]} ^ round_key[32*c +: 32];
      end else begin
        round_out[32*c +: 32] = mix_column(sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3])
                                ^ round_key[32*c +: 32];
      end
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    round_ctr_d = round_ctr_q;
    state_d     = state_q;
    out_block_d = out_block_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d     = in_block ^ round_keys[0 +: 128];
          round_ctr_d = 4'd1;
          busy_d      = 1'b1;
          fsm_d       = ROUND;
        end
      end
      ROUND: begin
        state_d = round_out;
        if (last_round) begin
          out_block_d = round_out;
          out_valid_d = 1'b1;
          fsm_d       = DONE;
        end else begin
          round_ctr_d = round_ctr_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          fsm_d       = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      round_ctr_q <= 4'd0;
      state_q     <= '0;
      out_block_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      round_ctr_q <= round_ctr_d;
      state_q     <= state_d;
      out_block_q <= out_block_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_block = out_block_q;
  assign busy      = busy_q;

endmodule
